// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage feeding decode, with redirect and wrong-path discard.
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [96:0] fetch_out
);
  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;
  state_t state, state_n;
  logic [63:0] pc, pc_n, req_addr, req_addr_n, out_pc, out_pc_n, tgt;
  logic [31:0] out_instr, out_instr_n;
  logic kill, kill_n;
  assign tgt = redirect_pc & ~64'd3;
  always_comb begin
    state_n = state;
    pc_n = pc;
    kill_n = kill;
    out_instr_n = out_instr;
    out_pc_n = out_pc;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid) pc_n = tgt;
      end
      REQ: begin
        if (iresp_data_ok) begin
          if (kill || redirect_valid) begin
            kill_n = 1'b0;
            if (redirect_valid) pc_n = tgt;
          end else begin
            out_instr_n = iresp_data;
            out_pc_n = pc;
            pc_n = pc + 64'd4;
            state_n = OUT;
          end
        end else if (redirect_valid) begin
          kill_n = 1'b1;
          pc_n = tgt;
        end
      end
      OUT: begin
        if (redirect_valid) pc_n = tgt;
        if (redirect_valid || !stall) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
    // the in-flight address is frozen until its response returns, even after a redirect moves pc
    req_addr_n = (state == REQ && !iresp_data_ok) ? req_addr : pc_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= PC_RESET;
      req_addr <= PC_RESET;
      kill <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_addr <= req_addr_n;
      kill <= kill_n;
      out_instr <= out_instr_n;
      out_pc <= out_pc_n;
    end
  end
  assign ireq_valid = state == REQ;
  assign ireq_addr = req_addr;
  assign fetch_out = {state == OUT, out_instr, out_pc};
  a_resp_only_in_req: assert property (@(posedge clk) disable iff (reset) iresp_data_ok |-> state == REQ);
endmodule
